// File: rtl/memory_pkg.sv
// Shared types for the memory-access pipeline stage: bus bundles, the
// execute->memory and memory->writeback pipeline registers, and FSM states.
package memory_pkg;

  // Common types: word type and data-bus request/response bundles
  typedef logic [31:0] u32;

  typedef struct packed {
    logic       valid;
    u32         addr;
    logic [3:0] strobe;
    u32         data;
  } dbus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u32   data;
  } dbus_resp_t;

  // Pipeline types: register bundles between stages and the bus FSM states
  typedef struct packed {
    u32         alu_result;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic [4:0] rt;
    logic [4:0] rd;
    u32         pc;
    u32         instruction;
  } e_m_reg_t;

  typedef struct packed {
    u32         wb_value;
    logic       reg_write;
    logic [4:0] dst;
    u32         pc;
    u32         instruction;
  } m_w_reg_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } mem_state_e;

  // An instruction needs the data bus if it is a load or a store
  function automatic logic is_mem_op(input e_m_reg_t r);
    return r.mem_to_reg | r.mem_write;
  endfunction

endpackage

// File: rtl/mem_fsm.sv
// Bus-transaction sequencer for the memory stage: state register,
// next-state selection, upstream stall and the load-data capture strobe.
module mem_fsm
  import memory_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_op,
  input  logic       skip_bus,
  input  logic       addr_ok,
  input  logic       data_ok,
  output mem_state_e state,
  output logic       mem_stall,
  output logic       data_capture
);

  // Walk one bus transaction: request until accepted, wait for data, then retire
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (mem_op) state <= skip_bus ? DONE : REQ;
        REQ: begin
          if (addr_ok && data_ok) state <= DONE;
          else if (addr_ok)       state <= WAIT;
        end
        WAIT: if (data_ok) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The stall releases in DONE so the next instruction is captured as this one retires
  assign mem_stall = mem_op & (state != DONE);

  // data_ok only counts once the request itself has been accepted
  assign data_capture = ((state == REQ) & addr_ok & data_ok) |
                        ((state == WAIT) & data_ok);

endmodule

// File: rtl/memory.sv
// Memory-access pipeline stage: captures the execute result, runs LW/SW over
// the valid/addr_ok/data_ok data bus, stalls upstream while a transaction is
// in flight and hands the writeback bundle downstream.
// Optional build macro MEM_ALIGN_CHECK_EN: misaligned loads/stores skip the
// bus, retire with reg_write=0 and pulse the extra misalign output.
module memory
  import memory_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  e_m_reg_t          e_m_reg,
  input  logic              e_m_valid,
  input  logic [DATA_W-1:0] store_data,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [STRB_W-1:0] dreq_strobe,
  output logic [DATA_W-1:0] dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [DATA_W-1:0] dresp_data,
  output m_w_reg_t          m_w_reg,
  output logic              m_w_valid,
  output logic              mem_stall
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misalign
`endif
);

  e_m_reg_t          e_m_q;
  logic              valid_q;
  logic [DATA_W-1:0] store_q;
  logic [DATA_W-1:0] rdata_q;
  mem_state_e        state;
  logic              mem_op;
  logic              addr_bad;
  logic              data_capture;
  logic [4:0]        dst;
  dbus_req_t         req;
  dbus_resp_t        resp;

  assign resp.addr_ok = dresp_addr_ok;
  assign resp.data_ok = dresp_data_ok;
  assign resp.data    = dresp_data;

  // Input register holds the instruction (and its store data) for the whole transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      e_m_q   <= '0;
      valid_q <= 1'b0;
      store_q <= '0;
    end else if (!mem_stall) begin
      e_m_q   <= e_m_reg;
      valid_q <= e_m_valid;
      store_q <= store_data;
    end
  end

  // Load data is only valid alongside data_ok, so it is kept for the DONE cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (data_capture) begin
      rdata_q <= resp.data;
    end
  end

  assign mem_op = valid_q & is_mem_op(e_m_q);

`ifdef MEM_ALIGN_CHECK_EN
  assign addr_bad = e_m_q.alu_result[1:0] != 2'b00;
  assign misalign = (state == DONE) & addr_bad;
`else
  assign addr_bad = 1'b0;
`endif

  mem_fsm u_fsm (
    .clk          (clk),
    .reset        (reset),
    .mem_op       (mem_op),
    .skip_bus     (addr_bad),
    .addr_ok      (resp.addr_ok),
    .data_ok      (resp.data_ok),
    .state        (state),
    .mem_stall    (mem_stall),
    .data_capture (data_capture)
  );

  // Request fields come straight from the stalled input register, so they stay stable until accepted
  always_comb begin
    req        = '0;
    req.valid  = (state == REQ);
    req.addr   = e_m_q.alu_result;
    req.strobe = e_m_q.mem_write ? 4'hF : 4'h0;
    req.data   = store_q;
  end

  assign dreq_valid  = req.valid;
  assign dreq_addr   = req.addr[ADDR_W-1:0];
  assign dreq_strobe = req.strobe[STRB_W-1:0];
  assign dreq_data   = req.data[DATA_W-1:0];

  assign dst = e_m_q.reg_dst ? e_m_q.rd : e_m_q.rt;

  // Non-memory instructions retire in their capture cycle; memory ops retire only in DONE
  always_comb begin
    m_w_reg   = '0;
    m_w_valid = 1'b0;
    case (state)
      IDLE: begin
        if (valid_q && !is_mem_op(e_m_q)) begin
          m_w_valid           = 1'b1;
          m_w_reg.wb_value    = e_m_q.alu_result;
          m_w_reg.reg_write   = e_m_q.reg_write;
          m_w_reg.dst         = dst;
          m_w_reg.pc          = e_m_q.pc;
          m_w_reg.instruction = e_m_q.instruction;
        end
      end
      DONE: begin
        m_w_valid           = 1'b1;
        m_w_reg.wb_value    = (e_m_q.mem_to_reg && !addr_bad) ? rdata_q : e_m_q.alu_result;
        m_w_reg.reg_write   = e_m_q.reg_write & e_m_q.mem_to_reg & ~addr_bad;
        m_w_reg.dst         = dst;
        m_w_reg.pc          = e_m_q.pc;
        m_w_reg.instruction = e_m_q.instruction;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_memory.sv
// Self-checking bench for the memory stage. Expected writeback bundles are
// queued when an instruction is presented and popped by a monitor whenever
// m_w_valid is seen; each scenario task also checks stall and bus signals.
module tb_memory;
  import memory_pkg::*;

  typedef struct {
    m_w_reg_t r;
    bit       wb_care;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  e_m_reg_t    e_m_reg = '0;
  logic        e_m_valid = 1'b0;
  logic [31:0] store_data = '0;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok = 1'b0;
  logic        dresp_data_ok = 1'b0;
  logic [31:0] dresp_data = '0;
  m_w_reg_t    m_w_reg;
  logic        m_w_valid;
  logic        mem_stall;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t mon_e;
  m_w_reg_t mon_act;

  memory dut (
    .clk           (clk),
    .reset         (reset),
    .e_m_reg       (e_m_reg),
    .e_m_valid     (e_m_valid),
    .store_data    (store_data),
    .dreq_valid    (dreq_valid),
    .dreq_addr     (dreq_addr),
    .dreq_strobe   (dreq_strobe),
    .dreq_data     (dreq_data),
    .dresp_addr_ok (dresp_addr_ok),
    .dresp_data_ok (dresp_data_ok),
    .dresp_data    (dresp_data),
    .m_w_reg       (m_w_reg),
    .m_w_valid     (m_w_valid),
    .mem_stall     (mem_stall)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .misalign      (misalign)
`endif
  );

  always #5 clk = ~clk;

  function automatic e_m_reg_t mk_op(input u32 alu, input bit ld, input bit st, input bit rw,
                                     input bit rdst, input logic [4:0] rt, input logic [4:0] rd,
                                     input u32 pc);
    e_m_reg_t r;
    r.alu_result  = alu;
    r.mem_to_reg  = ld;
    r.mem_write   = st;
    r.reg_write   = rw;
    r.reg_dst     = rdst;
    r.rt          = rt;
    r.rd          = rd;
    r.pc          = pc;
    r.instruction = pc ^ 32'hA5A5_0000;
    return r;
  endfunction

  function automatic exp_t mk_exp(input u32 wb, input bit rw, input logic [4:0] dst,
                                  input u32 pc, input bit care);
    exp_t e;
    e.r.wb_value    = wb;
    e.r.reg_write   = rw;
    e.r.dst         = dst;
    e.r.pc          = pc;
    e.r.instruction = pc ^ 32'hA5A5_0000;
    e.wb_care       = care;
    return e;
  endfunction

  // Scoreboard monitor: every writeback pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!reset) begin
      if (m_w_valid === 1'b1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_wb: got m_w_valid=1 pc=%h, want no writeback", m_w_reg.pc);
        end else begin
          mon_e   = sb.pop_front();
          mon_act = m_w_reg;
          if (!mon_e.wb_care) mon_act.wb_value = mon_e.r.wb_value;
          if (mon_act !== mon_e.r) begin
            miscompares++;
            $display("[TB] FAIL wb_bundle: got wb=%h rw=%b dst=%0d pc=%h, want wb=%h rw=%b dst=%0d pc=%h",
                     m_w_reg.wb_value, m_w_reg.reg_write, m_w_reg.dst, m_w_reg.pc,
                     mon_e.r.wb_value, mon_e.r.reg_write, mon_e.r.dst, mon_e.r.pc);
          end
        end
      end else begin
        vectors++;
        if (m_w_reg.reg_write !== 1'b0) begin
          miscompares++;
          $display("[TB] FAIL idle_reg_write: got %b, want 0", m_w_reg.reg_write);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({dreq_valid, m_w_valid, mem_stall} !== 3'b000 || m_w_reg !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got dreq_valid=%b m_w_valid=%b stall=%b m_w_reg=%h, want all zero",
               dreq_valid, m_w_valid, mem_stall, m_w_reg);
    end
    reset = 1'b0;
  endtask

  task automatic test_pass_through();
    @(negedge clk);
    e_m_reg = mk_op(32'h5, 0, 0, 1, 1, 5'd2, 5'd3, 32'h1000);
    e_m_valid = 1'b1;
    sb.push_back(mk_exp(32'h5, 1, 5'd3, 32'h1000, 1));
    @(negedge clk);
    vectors++;
    if ({m_w_valid, mem_stall, dreq_valid} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL addi_timing: got valid=%b stall=%b dreq=%b, want 1 0 0",
               m_w_valid, mem_stall, dreq_valid);
    end
    e_m_reg = mk_op(32'hCAFE_0001, 0, 0, 1, 0, 5'd9, 5'd4, 32'h1004);
    sb.push_back(mk_exp(32'hCAFE_0001, 1, 5'd9, 32'h1004, 1));
    @(negedge clk);
    e_m_reg = mk_op(32'h7, 0, 0, 0, 1, 5'd1, 5'd6, 32'h1008);
    sb.push_back(mk_exp(32'h7, 0, 5'd6, 32'h1008, 1));
    @(negedge clk);
    e_m_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (m_w_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bubble_valid: got %b, want 0", m_w_valid);
    end
  endtask

  task automatic test_lw();
    int stalls = 0;
    e_m_reg = mk_op(32'h100, 1, 0, 1, 0, 5'd5, 5'd0, 32'h2000);
    e_m_valid = 1'b1;
    sb.push_back(mk_exp(32'hDEAD_BEEF, 1, 5'd5, 32'h2000, 1));
    @(negedge clk);
    stalls += int'(mem_stall === 1'b1);
    vectors++;
    if (dreq_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lw_capture_dreq: got %b, want 0", dreq_valid);
    end
    e_m_valid = 1'b0;
    dresp_data_ok = 1'b1;
    dresp_data = 32'hBAD0_BAD0;
    @(negedge clk);
    stalls += int'(mem_stall === 1'b1);
    vectors++;
    if (dreq_valid !== 1'b1 || dreq_addr !== 32'h100 || dreq_strobe !== 4'h0) begin
      miscompares++;
      $display("[TB] FAIL lw_req: got valid=%b addr=%h strb=%h, want 1 00000100 0",
               dreq_valid, dreq_addr, dreq_strobe);
    end
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data = 32'h0;
    vectors++;
    if (m_w_valid !== 1'b1 || mem_stall !== 1'b0 || dreq_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lw_done: got valid=%b stall=%b dreq=%b, want 1 0 0",
               m_w_valid, mem_stall, dreq_valid);
    end
    vectors++;
    if (stalls != 2) begin
      miscompares++;
      $display("[TB] FAIL lw_stall_cycles: got %0d, want 2", stalls);
    end
    @(negedge clk);
    vectors++;
    if (m_w_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lw_single_pulse: got %b, want 0", m_w_valid);
    end
  endtask

  task automatic test_sw();
    e_m_reg = mk_op(32'h104, 0, 1, 0, 0, 5'd7, 5'd0, 32'h3000);
    e_m_valid = 1'b1;
    store_data = 32'h55;
    sb.push_back(mk_exp(32'h0, 0, 5'd7, 32'h3000, 0));
    @(negedge clk);
    e_m_valid = 1'b0;
    store_data = 32'hFFFF_0000;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      vectors++;
      if (dreq_valid !== 1'b1 || dreq_addr !== 32'h104 || dreq_strobe !== 4'hF ||
          dreq_data !== 32'h55 || mem_stall !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL sw_req_hold%0d: got valid=%b addr=%h strb=%h data=%h stall=%b, want 1 00000104 f 00000055 1",
                 k, dreq_valid, dreq_addr, dreq_strobe, dreq_data, mem_stall);
      end
      dresp_data_ok = (k == 1);
      dresp_addr_ok = (k == 3);
    end
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      dresp_addr_ok = 1'b0;
      vectors++;
      if (dreq_valid !== 1'b0 || mem_stall !== 1'b1 || m_w_valid !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL sw_wait%0d: got dreq=%b stall=%b valid=%b, want 0 1 0",
                 k, dreq_valid, mem_stall, m_w_valid);
      end
      dresp_data_ok = (k == 2);
    end
    @(negedge clk);
    dresp_data_ok = 1'b0;
    vectors++;
    if (m_w_valid !== 1'b1 || mem_stall !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sw_done: got valid=%b stall=%b, want 1 0", m_w_valid, mem_stall);
    end
    @(negedge clk);
    vectors++;
    if (m_w_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sw_single_pulse: got %b, want 0", m_w_valid);
    end
  endtask

  task automatic test_reset_mid();
    e_m_reg = mk_op(32'h200, 1, 0, 1, 0, 5'd11, 5'd0, 32'h4000);
    e_m_valid = 1'b1;
    @(negedge clk);
    e_m_valid = 1'b0;
    @(negedge clk);
    dresp_addr_ok = 1'b1;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    vectors++;
    if (dreq_valid !== 1'b0 || mem_stall !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_wait: got dreq=%b stall=%b, want 0 1", dreq_valid, mem_stall);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({dreq_valid, m_w_valid, mem_stall} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_abandon: got dreq=%b valid=%b stall=%b, want 0 0 0",
               dreq_valid, m_w_valid, mem_stall);
    end
    reset = 1'b0;
    dresp_data_ok = 1'b1;
    dresp_data = 32'h1234_5678;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    vectors++;
    if ({dreq_valid, m_w_valid, mem_stall} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_late_data: got dreq=%b valid=%b stall=%b, want 0 0 0",
               dreq_valid, m_w_valid, mem_stall);
    end
  endtask

  task automatic test_back_to_back();
    e_m_reg = mk_op(32'h300, 1, 0, 1, 0, 5'd8, 5'd0, 32'h5000);
    e_m_valid = 1'b1;
    sb.push_back(mk_exp(32'h0000_0111, 1, 5'd8, 32'h5000, 1));
    @(negedge clk);
    e_m_reg = mk_op(32'h304, 1, 0, 1, 1, 5'd0, 5'd12, 32'h5004);
    sb.push_back(mk_exp(32'h0000_0222, 1, 5'd12, 32'h5004, 1));
    @(negedge clk);
    vectors++;
    if (dreq_valid !== 1'b1 || dreq_addr !== 32'h300) begin
      miscompares++;
      $display("[TB] FAIL b2b_first_req: got valid=%b addr=%h, want 1 00000300", dreq_valid, dreq_addr);
    end
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data = 32'h111;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    @(negedge clk);
    e_m_valid = 1'b0;
    vectors++;
    if (mem_stall !== 1'b1 || m_w_valid !== 1'b0 || dreq_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_capture: got stall=%b valid=%b dreq=%b, want 1 0 0",
               mem_stall, m_w_valid, dreq_valid);
    end
    @(negedge clk);
    vectors++;
    if (dreq_valid !== 1'b1 || dreq_addr !== 32'h304) begin
      miscompares++;
      $display("[TB] FAIL b2b_second_req: got valid=%b addr=%h, want 1 00000304", dreq_valid, dreq_addr);
    end
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data = 32'h222;
    @(negedge clk);
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    @(negedge clk);
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_misalign();
    e_m_reg = mk_op(32'h102, 1, 0, 1, 0, 5'd13, 5'd0, 32'h6000);
    e_m_valid = 1'b1;
    sb.push_back(mk_exp(32'h0, 0, 5'd13, 32'h6000, 0));
    @(negedge clk);
    e_m_valid = 1'b0;
    vectors++;
    if (dreq_valid !== 1'b0 || misalign !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL misalign_capture: got dreq=%b misalign=%b, want 0 0", dreq_valid, misalign);
    end
    @(negedge clk);
    vectors++;
    if (dreq_valid !== 1'b0 || misalign !== 1'b1 || m_w_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL misalign_done: got dreq=%b misalign=%b valid=%b, want 0 1 1",
               dreq_valid, misalign, m_w_valid);
    end
    @(negedge clk);
    vectors++;
    if (misalign !== 1'b0 || dreq_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL misalign_pulse: got misalign=%b dreq=%b, want 0 0", misalign, dreq_valid);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pass_through();
    test_lw();
    test_sw();
    test_reset_mid();
    test_back_to_back();
`ifdef MEM_ALIGN_CHECK_EN
    test_misalign();
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
